// File: rtl/conv_kernel_mac.sv
// K x K convolution multiply-accumulate engine with a shadow/active configuration bank.
// Three registered stages: per-tap products, adder tree, round/shift/clamp.
module conv_kernel_mac #(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COEF_WIDTH  = 8,
    parameter int unsigned SHIFT_WIDTH = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     inPixel,
    input  logic                                              inPixelValid,
    input  logic                                              coefWrEn,
    input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]        coefAddr,
    input  logic signed [COEF_WIDTH-1:0]                      coefData,
    input  logic [SHIFT_WIDTH-1:0]                            cfgShift,
    input  logic [1:0]                                        cfgMode,
    input  logic                                              cfgCommit,
    output logic [DATA_WIDTH-1:0]                             outPixel,
    output logic                                              outPixelValid
);

    localparam int unsigned NPIX   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned CENTRE = (NPIX - 1) / 2;
    localparam int unsigned PW     = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int unsigned SW     = PW + $clog2(NPIX);
    localparam int unsigned EW     = SW + 2;

    localparam logic [1:0] MODE_ABS    = 2'd1;
    localparam logic [1:0] MODE_BYPASS = 2'd2;

    localparam logic signed [EW-1:0] PIX_MAX = EW'(2 ** DATA_WIDTH - 1);

    // Sharpen kernel: centre 5, the four direct neighbours -1, everything else 0.
    function automatic logic signed [COEF_WIDTH-1:0] default_coef(input int unsigned idx);
        int dr;
        int dc;
        dr = int'(idx / KERNEL_SIZE) - int'(CENTRE / KERNEL_SIZE);
        dc = int'(idx % KERNEL_SIZE) - int'(CENTRE % KERNEL_SIZE);
        if (dr == 0 && dc == 0) begin
            return COEF_WIDTH'(5);
        end
        if ((dr == 0 && (dc == 1 || dc == -1)) || (dc == 0 && (dr == 1 || dr == -1))) begin
            return COEF_WIDTH'(-1);
        end
        return '0;
    endfunction

    logic signed [COEF_WIDTH-1:0] shadow_coef_q [NPIX];
    logic signed [COEF_WIDTH-1:0] shadow_coef_d [NPIX];
    logic signed [COEF_WIDTH-1:0] active_coef_q [NPIX];
    logic signed [COEF_WIDTH-1:0] active_coef_d [NPIX];
    logic [SHIFT_WIDTH-1:0]       active_shift_q, active_shift_d;
    logic [1:0]                   active_mode_q, active_mode_d;

    logic                         s1_valid_q, s1_valid_d;
    logic signed [PW-1:0]         s1_prod_q [NPIX];
    logic signed [PW-1:0]         s1_prod_d [NPIX];
    logic [SHIFT_WIDTH-1:0]       s1_shift_q, s1_shift_d;
    logic [1:0]                   s1_mode_q, s1_mode_d;
    logic [DATA_WIDTH-1:0]        s1_centre_q, s1_centre_d;

    logic                         s2_valid_q, s2_valid_d;
    logic signed [SW-1:0]         s2_sum_q, s2_sum_d;
    logic [SHIFT_WIDTH-1:0]       s2_shift_q, s2_shift_d;
    logic [1:0]                   s2_mode_q, s2_mode_d;
    logic [DATA_WIDTH-1:0]        s2_centre_q, s2_centre_d;

    logic                         out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]        out_pixel_q, out_pixel_d;

    // Same-cycle write and commit: the write lands in shadow_d, which is what gets committed.
    always_comb begin
        shadow_coef_d  = shadow_coef_q;
        active_coef_d  = active_coef_q;
        active_shift_d = active_shift_q;
        active_mode_d  = active_mode_q;
        if (coefWrEn && (32'(coefAddr) < NPIX)) begin
            shadow_coef_d[coefAddr] = coefData;
        end
        if (cfgCommit) begin
            active_coef_d  = shadow_coef_d;
            active_shift_d = cfgShift;
            active_mode_d  = cfgMode;
        end
    end

    // Stage 1: per-tap products, config sampled alongside the window.
    always_comb begin
        logic signed [PW-1:0] pix_s;
        logic signed [PW-1:0] coef_s;
        pix_s       = '0;
        coef_s      = '0;
        s1_valid_d  = inPixelValid;
        s1_prod_d   = s1_prod_q;
        s1_shift_d  = s1_shift_q;
        s1_mode_d   = s1_mode_q;
        s1_centre_d = s1_centre_q;
        if (inPixelValid) begin
            for (int unsigned i = 0; i < NPIX; i++) begin
                pix_s        = PW'($signed({1'b0, inPixel[i*DATA_WIDTH +: DATA_WIDTH]}));
                coef_s       = PW'(active_coef_q[i]);
                s1_prod_d[i] = pix_s * coef_s;
            end
            s1_shift_d  = active_shift_q;
            s1_mode_d   = active_mode_q;
            s1_centre_d = inPixel[CENTRE*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Stage 2: full-precision sum of all taps.
    always_comb begin
        s2_valid_d  = s1_valid_q;
        s2_sum_d    = s2_sum_q;
        s2_shift_d  = s2_shift_q;
        s2_mode_d   = s2_mode_q;
        s2_centre_d = s2_centre_q;
        if (s1_valid_q) begin
            s2_sum_d = '0;
            for (int unsigned i = 0; i < NPIX; i++) begin
                s2_sum_d = s2_sum_d + SW'(s1_prod_q[i]);
            end
            s2_shift_d  = s1_shift_q;
            s2_mode_d   = s1_mode_q;
            s2_centre_d = s1_centre_q;
        end
    end

    // Stage 3: optional magnitude, round-half-up shift, clamp to pixel range.
    always_comb begin
        logic signed [EW-1:0] val;
        logic signed [EW-1:0] rnd;
        logic signed [EW-1:0] res;
        val         = EW'(s2_sum_q);
        rnd         = '0;
        res         = '0;
        out_valid_d = s2_valid_q;
        out_pixel_d = out_pixel_q;
        if (s2_mode_q == MODE_ABS && s2_sum_q < 0) begin
            val = -val;
        end
        if (s2_shift_q != '0) begin
            rnd = EW'(1) << (s2_shift_q - SHIFT_WIDTH'(1));
        end
        res = (val + rnd) >>> s2_shift_q;
        if (s2_valid_q) begin
            if (s2_mode_q == MODE_BYPASS) begin
                out_pixel_d = s2_centre_q;
            end else if (res < 0) begin
                out_pixel_d = '0;
            end else if (res > PIX_MAX) begin
                out_pixel_d = PIX_MAX[DATA_WIDTH-1:0];
            end else begin
                out_pixel_d = res[DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NPIX; i++) begin
                shadow_coef_q[i] <= default_coef(i);
                active_coef_q[i] <= default_coef(i);
                s1_prod_q[i]     <= '0;
            end
            active_shift_q <= '0;
            active_mode_q  <= '0;
            s1_valid_q     <= 1'b0;
            s1_shift_q     <= '0;
            s1_mode_q      <= '0;
            s1_centre_q    <= '0;
            s2_valid_q     <= 1'b0;
            s2_sum_q       <= '0;
            s2_shift_q     <= '0;
            s2_mode_q      <= '0;
            s2_centre_q    <= '0;
            out_valid_q    <= 1'b0;
            out_pixel_q    <= '0;
        end else begin
            shadow_coef_q  <= shadow_coef_d;
            active_coef_q  <= active_coef_d;
            active_shift_q <= active_shift_d;
            active_mode_q  <= active_mode_d;
            s1_valid_q     <= s1_valid_d;
            s1_prod_q      <= s1_prod_d;
            s1_shift_q     <= s1_shift_d;
            s1_mode_q      <= s1_mode_d;
            s1_centre_q    <= s1_centre_d;
            s2_valid_q     <= s2_valid_d;
            s2_sum_q       <= s2_sum_d;
            s2_shift_q     <= s2_shift_d;
            s2_mode_q      <= s2_mode_d;
            s2_centre_q    <= s2_centre_d;
            out_valid_q    <= out_valid_d;
            out_pixel_q    <= out_pixel_d;
        end
    end

    assign outPixel      = out_pixel_q;
    assign outPixelValid = out_valid_q;

endmodule

// File: tb/tb_conv_kernel_mac.sv
// Scoreboard bench for conv_kernel_mac: driver predicts with an integer model, monitor checks outputs.
module tb_conv_kernel_mac;

    localparam int K    = 3;
    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int SHW  = 4;
    localparam int NPIX = K * K;
    localparam int AW   = $clog2(NPIX);
    localparam int CTR  = (NPIX - 1) / 2;
    localparam int LAT  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NPIX*DW-1:0]   inPixel;
    logic                 inPixelValid;
    logic                 coefWrEn;
    logic [AW-1:0]        coefAddr;
    logic signed [CW-1:0] coefData;
    logic [SHW-1:0]       cfgShift;
    logic [1:0]           cfgMode;
    logic                 cfgCommit;
    logic [DW-1:0]        outPixel;
    logic                 outPixelValid;

    conv_kernel_mac #(
        .KERNEL_SIZE(K), .DATA_WIDTH(DW), .COEF_WIDTH(CW), .SHIFT_WIDTH(SHW)
    ) dut (
        .clk(clk), .rst(rst), .inPixel(inPixel), .inPixelValid(inPixelValid),
        .coefWrEn(coefWrEn), .coefAddr(coefAddr), .coefData(coefData),
        .cfgShift(cfgShift), .cfgMode(cfgMode), .cfgCommit(cfgCommit),
        .outPixel(outPixel), .outPixelValid(outPixelValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    val;
        int    due;
        string name;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last_out = 0;

    int m_sh[NPIX];
    int m_ac[NPIX];
    int m_shift;
    int m_mode;

    int    win[NPIX];
    bit    d_v, d_wr, d_commit;
    int    d_addr, d_data, d_shift, d_mode;
    string d_name;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic void model_reset();
        m_sh    = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
        m_ac    = m_sh;
        m_shift = 0;
        m_mode  = 0;
    endfunction

    // Reference: plain integer convolution, then the mode rules.
    function automatic int model_out();
        int s = 0;
        if (m_mode == 2) return win[CTR];
        for (int i = 0; i < NPIX; i++) s += win[i] * m_ac[i];
        if (m_mode == 1 && s < 0) s = -s;
        if (m_shift > 0) s += (1 << (m_shift - 1));
        s = s >>> m_shift;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    function automatic logic [NPIX*DW-1:0] pack_win();
        logic [NPIX*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NPIX; i++) v[i*DW +: DW] = DW'(win[i]);
        return v;
    endfunction

    task automatic step();
        exp_t e;
        inPixel      = pack_win();
        inPixelValid = d_v;
        coefWrEn     = d_wr;
        coefAddr     = AW'(d_addr);
        coefData     = CW'(d_data);
        cfgCommit    = d_commit;
        cfgShift     = SHW'(d_shift);
        cfgMode      = 2'(d_mode);
        if (d_v) begin
            e.val  = model_out();
            e.due  = cyc + LAT;
            e.name = d_name;
            sbq.push_back(e);
        end
        if (d_wr && d_addr < NPIX) m_sh[d_addr] = d_data;
        if (d_commit) begin
            m_ac    = m_sh;
            m_shift = d_shift;
            m_mode  = d_mode;
        end
        @(posedge clk);
        #1;
        d_v = 0; d_wr = 0; d_commit = 0;
    endtask

    task automatic fill(input int centre, input int others);
        for (int i = 0; i < NPIX; i++) win[i] = others;
        win[CTR] = centre;
    endtask

    task automatic rand_win();
        for (int i = 0; i < NPIX; i++) win[i] = int'($urandom_range(0, 255));
    endtask

    task automatic send(input string nm);
        d_v = 1; d_name = nm;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_coef(input int addr, input int data, input bit commit,
                              input int sh, input int md);
        d_wr = 1; d_addr = addr; d_data = data;
        d_commit = commit; d_shift = sh; d_mode = md;
        step();
    endtask

    task automatic commit(input int sh, input int md);
        d_commit = 1; d_shift = sh; d_mode = md;
        step();
    endtask

    // Monitor: pops the scoreboard on every valid output, also checks hold and missing outputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (outPixelValid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check({e.name, "_pixel"}, int'(outPixel), e.val);
                    check({e.name, "_latency"}, cyc, e.due);
                    last_out = e.val;
                end
            end else begin
                check("hold_pixel", int'(outPixel), last_out);
                if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                    exp_t e;
                    e = sbq.pop_front();
                    check({e.name, "_missing"}, 0, 1);
                end
            end
        end
    end

    initial begin
        d_v = 0; d_wr = 0; d_commit = 0; d_addr = 0; d_data = 0; d_shift = 0; d_mode = 0;
        d_name = "idle";
        fill(0, 0);
        inPixel = '0; inPixelValid = 0; coefWrEn = 0; coefAddr = '0; coefData = '0;
        cfgShift = '0; cfgMode = '0; cfgCommit = 0;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", int'(outPixelValid), 0);
        check("reset_pixel", int'(outPixel), 0);
        model_reset();
        rst = 0;
        idle(2);

        // Default sharpen kernel.
        fill(1, 1);    send("sharpen_ones");  idle(5);
        fill(255, 0);  send("centre_sat");
        fill(0, 255);  send("neg_clamp");
        idle(4);
        commit(0, 1);
        fill(0, 255);  send("abs_mode");
        idle(4);

        // Box kernel with shift 3; last write committed in the same cycle.
        for (int i = 0; i < NPIX - 1; i++) write_coef(i, 1, 0, 0, 0);
        write_coef(NPIX - 1, 1, 1, 3, 0);
        fill(8, 8);    send("box_eights");
        fill(12, 8);   send("box_round76");
        idle(4);

        // Write and commit together: centre becomes 3.
        write_coef(CTR, 3, 1, 0, 0);
        fill(10, 0);   send("wr_commit_same");
        idle(4);

        // Out-of-range address must be ignored.
        write_coef(NPIX + 2, 7, 1, 0, 0);
        fill(10, 1);   send("addr_oob");
        idle(4);

        // Back-to-back stream with a kernel change landing on window 5.
        write_coef(0, 2, 0, 0, 0);
        write_coef(8, -2, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            rand_win();
            if (i == 5) begin
                d_commit = 1; d_shift = 1; d_mode = 1;
            end
            send($sformatf("stream%0d", i));
        end
        idle(4);

        // Bypass with an arbitrary kernel.
        for (int i = 0; i < NPIX; i++) write_coef(i, int'($urandom_range(0, 255)) - 128, 0, 0, 0);
        commit(5, 2);
        rand_win(); win[CTR] = 'h5A; send("bypass_5a");
        idle(4);

        // Randomised traffic with bubbles, writes and commits.
        for (int n = 0; n < 400; n++) begin
            rand_win();
            d_v = ($urandom_range(0, 3) != 0);
            d_name = "random";
            if ($urandom_range(0, 7) == 0) begin
                d_wr = 1;
                d_addr = int'($urandom_range(0, (1 << AW) - 1));
                d_data = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 255)) - 128
                                                     : int'($urandom_range(0, 8)) - 4;
            end
            if ($urandom_range(0, 19) == 0) begin
                d_commit = 1;
                d_shift  = int'($urandom_range(0, 15));
                d_mode   = int'($urandom_range(0, 3));
            end
            step();
        end
        idle(5);

        // Reset with two windows in flight.
        write_coef(CTR, 9, 1, 2, 1);
        fill(1, 1);   send("pre_reset_a");
        rand_win();   send("pre_reset_b");
        rst = 1;
        sbq.delete();
        #1;
        check("midreset_valid", int'(outPixelValid), 0);
        check("midreset_pixel", int'(outPixel), 0);
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        last_out = 0;
        rst = 0;
        idle(5);
        fill(1, 1);   send("post_reset_ones");
        idle(5);
        fill(255, 0); send("post_reset_centre");
        for (int n = 0; n < 20; n++) begin
            rand_win();
            send("post_reset_rand");
        end
        idle(LAT + 3);

        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            check({e.name, "_never_seen"}, 0, 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d compared so far", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
